// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, op encodings and state type for the multiply/divide unit
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    // Counter value seen on the last CALC edge
    localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which read as unsigned is the correct magnitude 2^31.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring-divide iteration on a 64-bit accumulator
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              div_mode,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] src;
    logic [XLEN:0] addend;
    logic          cin;
    logic [XLEN:0] sum;
    logic          borrow;

    // Shared 33-bit adder: multiply adds the multiplicand to the high word,
    // divide subtracts the divisor from the left-shifted partial remainder.
    always_comb begin
        if (div_mode) begin
            src    = acc[2*XLEN-1:XLEN-1];
            addend = ~{1'b0, operand};
            cin    = 1'b1;
        end else begin
            src    = {1'b0, acc[2*XLEN-1:XLEN]};
            addend = {1'b0, operand};
            cin    = 1'b0;
        end
        sum = src + addend + {{XLEN{1'b0}}, cin};
    end

    // Select the shifted accumulator; in divide mode the low word collects quotient bits.
    // A set top bit in the shifted remainder already exceeds any 32-bit divisor,
    // so only a wrap with that bit clear is a real borrow.
    always_comb begin
        borrow   = 1'b0;
        acc_next = acc;
        if (div_mode) begin
            borrow = ~src[XLEN] & sum[XLEN];
            if (borrow) begin
                acc_next = {src[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU into HI/LO; MTHI/MTLO ports under MULDIV_MTHILO_EN
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
`ifdef MULDIV_MTHILO_EN
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wr_data,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_t         state_q;
    md_state_t         state_d;
    logic [4:0]        cnt_q;
    logic [1:0]        op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd_q;
    logic              sign_pq_q;
    logic              sign_r_q;
    logic              dz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;

    logic              wr_any;
    logic              load_en;
    logic              fix_en;
    logic              in_signed;
    logic              in_div;
    logic [XLEN-1:0]   a_in;
    logic [XLEN-1:0]   b_in;
    logic              run_div;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

`ifdef MULDIV_MTHILO_EN
    assign wr_any = wr_hi | wr_lo;
`else
    assign wr_any = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a register write in IDLE swallows a simultaneous start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !wr_any) state_d = CALC;
            CALC:    if (cnt_q == LAST_ITER) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy covers CALC and FIX
    always_comb begin
        busy    = (state_q != IDLE);
        load_en = (state_q == IDLE) && start && !wr_any;
        fix_en  = (state_q == FIX);
    end

    // Operand conditioning for capture: signed ops run on magnitudes
    always_comb begin
        in_signed = (op == MD_MULT) || (op == MD_DIV);
        in_div    = (op == MD_DIV) || (op == MD_DIVU);
        a_in      = in_signed ? abs_val(a) : a;
        b_in      = in_signed ? abs_val(b) : b;
        run_div   = (op_q == MD_DIV) || (op_q == MD_DIVU);
    end

    muldiv_step u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .div_mode (run_div),
        .acc_next (acc_next)
    );

    // Sign fix-up of the unsigned result; a zero divisor keeps the all-ones quotient
    always_comb begin
        prod = sign_pq_q ? -acc_q : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        if (sign_pq_q && !dz_q) begin
            quo = -acc_q[XLEN-1:0];
        end
        if (sign_r_q) begin
            rem = -acc_q[2*XLEN-1:XLEN];
        end
        if (run_div) begin
            fix_hi = rem;
            fix_lo = quo;
        end else begin
            fix_hi = prod[2*XLEN-1:XLEN];
            fix_lo = prod[XLEN-1:0];
        end
    end

    // Datapath: operand capture, iteration, and HI/LO update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            sign_pq_q <= 1'b0;
            sign_r_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= fix_en;
            if (load_en) begin
                op_q      <= op;
                cnt_q     <= '0;
                acc_q     <= {{XLEN{1'b0}}, (in_div ? a_in : b_in)};
                opnd_q    <= in_div ? b_in : a_in;
                sign_pq_q <= in_signed & (a[XLEN-1] ^ b[XLEN-1]);
                sign_r_q  <= in_signed & a[XLEN-1];
                dz_q      <= (b == '0);
            end else if (state_q == CALC) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + 5'd1;
            end

            if (fix_en) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
`ifdef MULDIV_MTHILO_EN
            else if (state_q == IDLE) begin
                if (wr_hi) hi_q <= wr_data;
                if (wr_lo) lo_q <= wr_data;
            end
`endif
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_MTHILO_EN
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    muldiv_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
`ifdef MULDIV_MTHILO_EN
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
`endif
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // MIPS HI/LO results from plain integer arithmetic, returned as {hi, lo}
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int     sx;
        int     sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            MD_MULT: begin
                p = longint'(sx) * longint'(sy);
                return 64'(p);
            end
            MD_MULTU: return {32'h0, x} * {32'h0, y};
            MD_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops an expectation on every done pulse; hi/lo must hold while busy
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                check("done_single_cycle", 32'(prev_done), 32'h0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done with empty scoreboard required=no done");
                end else begin
                    mon_e = sbq.pop_front();
                    check({mon_e.name, "_hi"}, hi, mon_e.hi);
                    check({mon_e.name, "_lo"}, lo, mon_e.lo);
                    check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
                end
            end
            if (busy === 1'b1 && prev_busy === 1'b1) begin
                check("hold_hi_while_busy", hi, prev_hi);
                check("hold_lo_while_busy", lo, prev_lo);
            end
        end
        prev_busy = busy;
        prev_done = done;
        prev_hi   = hi;
        prev_lo   = lo;
    end

    // Driver phase: all calls happen #1 after a rising edge
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=busy after 100 cycles required=idle");
        end
    endtask

    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        exp_t        e;
        wait_idle();
        r      = ref_model(o, x, y);
        e.hi   = r[63:32];
        e.lo   = r[31:0];
        e.due  = cyc + 34;
        e.name = name;
        sbq.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'h1);
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        logic [31:0] wd;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
`ifdef MULDIV_MTHILO_EN
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = 32'h0;
`endif
        #1;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_hi", hi, 32'h0);

        issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7);
        issue("mult_min_sq", MD_MULT, 32'h8000_0000, 32'h8000_0000);
        issue("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        issue("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("divu_by0", MD_DIVU, 32'd5, 32'd0);
        issue("div_by0", MD_DIV, 32'hFFFF_FFF9, 32'd0);

        // start pulsed mid-operation must be ignored
        issue("multu_busy", MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        op    = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'h1);
        wait_idle();
        check("b2b_issue_in_done_cycle", 32'(done), 32'h1);
        issue("divu_b2b", MD_DIVU, 32'd100, 32'd7);

        for (int i = 0; i < 40; i++) begin
            issue("random", 2'($urandom), pick_val(), pick_val());
        end

        // reset in the middle of an operation
        issue("mult_abort", MD_MULT, $urandom, $urandom);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue("after_abort", MD_DIV, 32'hFFFF_FF9C, 32'd7);

`ifdef MULDIV_MTHILO_EN
        wait_idle();
        @(posedge clk);
        #1;
        saved   = lo;
        wd      = $urandom;
        wr_data = wd;
        wr_hi   = 1'b1;
        op      = MD_MULTU;
        a       = 32'd3;
        b       = 32'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        start = 1'b0;
        check("mthi_hi", hi, wd);
        check("mthi_lo_kept", lo, saved);
        check("mthi_no_start", 32'(busy), 32'h0);
        saved   = hi;
        wd      = $urandom;
        wr_data = wd;
        wr_lo   = 1'b1;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo_lo", lo, wd);
        check("mtlo_hi_kept", hi, saved);
        issue("mtlo_while_busy", MD_MULT, 32'hFFFF_FF00, 32'd77);
        wr_lo   = 1'b1;
        wr_hi   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        wr_lo = 1'b0;
        wr_hi = 1'b0;
`endif

        wait_idle();
        repeat (40) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
